// File: rtl/xy_input_conditioner.sv
// Synchronizes and debounces the raw {x,y} pair as a unit for the Moore controller.
// Reports each committed change and keeps a saturating count of abandoned transitions.
module xy_input_conditioner #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       raw_x,
  input  logic       raw_y,
  output logic       in_x,
  output logic       in_y,
  output logic       pair_changed,
  output logic [7:0] glitch_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       cand;
  logic [1:0]       out;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer per raw bit; bit 1 is x, bit 0 is y.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the synchronizer stages do not collapse into one.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {raw_x, raw_y};
      s2 <= s1;
    end
  end

  // Debounce: any disagreement with the candidate restarts the count and takes
  // priority over a commit that would otherwise land on the same edge.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cand         <= 2'b00;
      cnt          <= '0;
      out          <= 2'b00;
      pair_changed <= 1'b0;
      glitch_count <= 8'd0;
    end else begin
      pair_changed <= 1'b0;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
        if ((cand != out) && (glitch_count != 8'hFF)) begin
          glitch_count <= glitch_count + 8'd1;
        end
      end else if (cand != out) begin
        if (cnt == CNT_LAST) begin
          out          <= cand;
          pair_changed <= 1'b1;
          cnt          <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign in_x = out[1];
  assign in_y = out[0];

endmodule

// File: tb/tb_xy_input_conditioner.sv
// Directed self-checking bench for xy_input_conditioner at default parameters.
// Edge numbering follows the sampling edge of a new raw pair as edge 1.
module tb_xy_input_conditioner;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       raw_x = 1'b0;
  logic       raw_y = 1'b0;
  logic       in_x;
  logic       in_y;
  logic       pair_changed;
  logic [7:0] glitch_count;

  int n_cmp = 0;
  int n_err = 0;
  int pc_pulses = 0;
  int pc_base = 0;

  xy_input_conditioner dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .raw_x        (raw_x),
    .raw_y        (raw_y),
    .in_x         (in_x),
    .in_y         (in_y),
    .pair_changed (pair_changed),
    .glitch_count (glitch_count)
  );

  always #5 clk = ~clk;

  // Counts pair_changed pulses mid-cycle, independent of the directed checks.
  always @(negedge clk) begin
    if (pair_changed === 1'b1) pc_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_raw(input logic [1:0] p);
    {raw_x, raw_y} = p;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    #2;
    reset_b = 1'b1;
  endtask

  task automatic glitch_pulse();
    set_raw(2'b01);
    step(2);
    set_raw(2'b00);
    step(2);
  endtask

  initial begin
    // Reset then idle
    #1;
    check("rst_pair",   {30'd0, in_x, in_y}, 32'd0);
    check("rst_pc",     {31'd0, pair_changed}, 32'd0);
    check("rst_glitch", {24'd0, glitch_count}, 32'd0);
    #1;
    reset_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_pair",   {30'd0, in_x, in_y}, 32'd0);
      check("idle_pc",     {31'd0, pair_changed}, 32'd0);
      check("idle_glitch", {24'd0, glitch_count}, 32'd0);
    end

    // Clean change 00 -> 01: commit at edge 7
    set_raw(2'b01);
    step(6);
    check("clean_pre_pair", {30'd0, in_x, in_y}, 32'd0);
    check("clean_pre_pc",   {31'd0, pair_changed}, 32'd0);
    step(1);
    check("clean_commit_pair", {30'd0, in_x, in_y}, 32'd1);
    check("clean_commit_pc",   {31'd0, pair_changed}, 32'd1);
    step(1);
    check("clean_post_pair", {30'd0, in_x, in_y}, 32'd1);
    check("clean_post_pc",   {31'd0, pair_changed}, 32'd0);
    check("clean_glitch",    {24'd0, glitch_count}, 32'd0);

    // Glitch rejection: 11 for 3 cycles then back to 00
    set_raw(2'b00);
    do_reset();
    pc_base = pc_pulses;
    set_raw(2'b11);
    step(3);
    set_raw(2'b00);
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("glitch_pair", {30'd0, in_x, in_y}, 32'd0);
    end
    check("glitch_count", {24'd0, glitch_count}, 32'd1);
    check("glitch_no_pc", pc_pulses - pc_base, 32'd0);

    // Pair change mid-debounce: 10 for 4 cycles, then 11 held (11 sampled at edge 5)
    do_reset();
    pc_base = pc_pulses;
    set_raw(2'b10);
    step(4);
    set_raw(2'b11);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("mid_pre_pair", {30'd0, in_x, in_y}, 32'd0);
    end
    step(1);
    check("mid_commit_pair", {30'd0, in_x, in_y}, 32'd3);
    check("mid_commit_pc",   {31'd0, pair_changed}, 32'd1);
    check("mid_glitch",      {24'd0, glitch_count}, 32'd1);
    step(2);
    check("mid_pc_total", pc_pulses - pc_base, 32'd1);

    // Reset mid-debounce: 01 held, reset between edges 4 and 5
    set_raw(2'b00);
    do_reset();
    step(2);
    set_raw(2'b01);
    step(4);
    reset_b = 1'b0;
    #1;
    check("rmid_in_pair",   {30'd0, in_x, in_y}, 32'd0);
    check("rmid_in_pc",     {31'd0, pair_changed}, 32'd0);
    check("rmid_in_glitch", {24'd0, glitch_count}, 32'd0);
    #1;
    reset_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("rmid_pre_pair", {30'd0, in_x, in_y}, 32'd0);
    end
    step(1);
    check("rmid_commit_pair", {30'd0, in_x, in_y}, 32'd1);
    check("rmid_commit_pc",   {31'd0, pair_changed}, 32'd1);
    check("rmid_glitch",      {24'd0, glitch_count}, 32'd0);

    // Saturation: 300 abandoned one-cycle-stable changes
    set_raw(2'b00);
    do_reset();
    pc_base = pc_pulses;
    repeat (254) glitch_pulse();
    step(4);
    check("sat_254", {24'd0, glitch_count}, 32'd254);
    glitch_pulse();
    step(4);
    check("sat_255", {24'd0, glitch_count}, 32'd255);
    repeat (45) glitch_pulse();
    step(4);
    check("sat_hold",  {24'd0, glitch_count}, 32'd255);
    check("sat_pair",  {30'd0, in_x, in_y}, 32'd0);
    check("sat_no_pc", pc_pulses - pc_base, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
